demux_1to4_16bit_stream: RTL and testbench
==========================================

// Module: demux_1to4_16bit_stream
// PURPOSE
//  Inverse of the team's 4:1 16-bit data mux: one valid/ready input stream is steered by a
//  per-beat 2-bit select to one of four output channels.
//  Each channel has a one-entry registered slot, so a stalled channel never blocks the others
//  unless the incoming beat targets it. Saturating per-channel beat counters support debug.
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  WIDTH      16  data width per beat
//  SEL_WIDTH  2   select width; channel count = 4 (fixed, 1<<SEL_WIDTH)
//  CNT_WIDTH  8   width of each per-channel beat counter
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous reset, active-high
//  in_valid   in   1            input beat valid
//  in_ready   out  1            input beat accepted when in_valid&&in_ready
//  in_data    in   WIDTH        input beat payload
//  in_sel     in   SEL_WIDTH    destination channel for this beat (0..3)
//  out_valid  out  4            per-channel slot valid; bit i = channel i
//  out_ready  in   4            per-channel consumer ready
//  out_data   out  4*WIDTH      channel i payload at [i*WIDTH +: WIDTH]
//  cnt_clr    in   1            synchronous clear of all beat counters
//  beat_cnt   out  4*CNT_WIDTH  channel i accepted-beat count at [i*CNT_WIDTH +: CNT_WIDTH]
// BEHAVIOUR
//  Clock and reset:
//   - One clock domain (clk). rst is asynchronous and active-high.
//  Reset values:
//   - out_valid=0, out_data=0, beat_cnt=0.
//   - in_ready is combinational and reads 1 while rst is deasserted and all slots are empty.
//  Per-channel slot i (1 entry: valid bit + WIDTH data):
//   - drain_i = out_valid[i] && out_ready[i]
//   - load_i  = in_valid && in_ready && (in_sel == i)
//   - Slot update each cycle:
//     - load_i: data_i <= in_data, valid_i <= 1 (takes priority over drain_i).
//     - else drain_i: valid_i <= 0; data_i holds its old value.
//     - else: slot holds.
//  Input ready (combinational, no dependency on in_valid):
//   - in_ready = !out_valid[in_sel] || out_ready[in_sel]
//   - A full slot that drains in the same cycle accepts a new beat: back-to-back throughput is
//     1 beat/clk per channel.
//  Latency:
//   - A beat accepted at edge N appears on out_valid/out_data of its channel after edge N.
//   - Latency is 1 cycle; there is no combinational path from in_data to out_data.
//  Ordering:
//   - Beats to the same channel are delivered in acceptance order.
//   - There is no ordering between channels.
//  Head-of-line blocking:
//   - If the target slot is full and not draining, in_ready=0.
//   - The producer holds in_data/in_sel stable until accepted (AXI-style; in_sel is part of
//     the payload).
//   - Other slots continue to drain independently.
//  out_data[i]:
//   - Holds its last value while valid_i=0.
//   - Consumers must qualify out_data[i] with out_valid[i].
//  Counters:
//   - beat_cnt[i] increments on load_i and saturates at 2^CNT_WIDTH-1 (no wrap).
//   - cnt_clr has priority: a clear in the same cycle as a load yields 0.
//   - A load in the following cycle yields 1.
//  Reset mid-operation:
//   - All slots are emptied immediately (asynchronously) and in-flight beats are discarded.
//   - Counters return to 0.
// TESTING
//  1. Reset, all out_ready=1; send D=16'hA5A5 sel=2 -> next cycle out_valid=4'b0100,
//     ch2 data=A5A5, beat_cnt[2]=1.
//  2. ch1 out_ready=0; send 16'h0001 sel=1, then 16'h0002 sel=1 -> second beat stalls
//     (in_ready=0) until out_ready[1]=1; ch1 delivers 0001 then 0002.
//  3. ch1 full and stalled; beat sel=3 16'hBEEF -> in_ready=1 (target ch3 empty), accepted;
//     ch3 valid next cycle, ch1 unchanged.
//  4. Streaming: 8 consecutive beats sel=0 with out_ready[0]=1 -> in_ready stays 1, 8 beats
//     out in order at 1/clk, beat_cnt[0]=8.
//  5. CNT_WIDTH=8: 300 beats to ch3 -> beat_cnt[3]=255; cnt_clr with a simultaneous load ->
//     0, next load -> 1.
//  6. Assert rst while ch0 and ch2 are valid -> out_valid=0 and beat_cnt=0 without waiting
//     for clk; after deassert a new beat behaves as in scenario 1.

Source files
------------

// File: rtl/demux_1to4_16bit_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_16bit_stream
// Brief    : 1:4 valid/ready stream demux with a one-entry slot and a
//            saturating beat counter per output channel.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to4_16bit_stream #(
    parameter int WIDTH     = 16,
    parameter int SEL_WIDTH = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH-1:0]                     in_data,
    input  logic [SEL_WIDTH-1:0]                 in_sel,
    output logic [(1<<SEL_WIDTH)-1:0]            out_valid,
    input  logic [(1<<SEL_WIDTH)-1:0]            out_ready,
    output logic [(1<<SEL_WIDTH)*WIDTH-1:0]      out_data,
    input  logic                                 cnt_clr,
    output logic [(1<<SEL_WIDTH)*CNT_WIDTH-1:0]  beat_cnt
);

    localparam int NCH = 1 << SEL_WIDTH;

    logic w_accept;

    // A full target slot that drains this cycle can take the next beat.
    assign in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);
    assign w_accept = in_valid && in_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic                 w_load;
        logic                 w_drain;
        logic                 valid_q;
        logic                 valid_d;
        logic [WIDTH-1:0]     data_q;
        logic [WIDTH-1:0]     data_d;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic [CNT_WIDTH-1:0] cnt_d;

        assign w_load  = w_accept && (in_sel == SEL_WIDTH'(i));
        assign w_drain = valid_q && out_ready[i];

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (w_load) begin
                valid_d = 1'b1;
                data_d  = in_data;
            end else if (w_drain) begin
                valid_d = 1'b0;
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (w_load && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                cnt_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                cnt_q   <= cnt_d;
            end
        end

        assign out_valid[i]                         = valid_q;
        assign out_data[i*WIDTH +: WIDTH]           = data_q;
        assign beat_cnt[i*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1to4_16bit_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_1to4_16bit_stream
// Brief    : Directed self-checking bench for demux_1to4_16bit_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to4_16bit_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] out_data;
    logic        cnt_clr;
    logic [31:0] beat_cnt;

    int n_assert;
    int n_fail;

    demux_1to4_16bit_stream #(
        .WIDTH     (16),
        .SEL_WIDTH (2),
        .CNT_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dat(input int ch);
        return out_data[ch*16 +: 16];
    endfunction

    function automatic logic [7:0] cnt(input int ch);
        return beat_cnt[ch*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = 4'hF;
        cnt_clr   = 1'b0;

        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  out_data,       64'h0);
        chk("rst_beat_cnt",  64'(beat_cnt),  64'h0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'h1);

        // Scenario 1: single beat to ch2
        in_valid = 1'b1; in_data = 16'hA5A5; in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        chk("s1_out_valid", 64'(out_valid), 64'h4);
        chk("s1_ch2_data",  64'(dat(2)),    64'hA5A5);
        chk("s1_ch2_cnt",   64'(cnt(2)),    64'h1);
        step();
        chk("s1_drained", 64'(out_valid), 64'h0);

        // Scenario 2/3: ch1 stalls, ch3 still accepts
        out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 16'h0001; in_sel = 2'd1;
        step();
        chk("s2_ch1_data0", 64'(dat(1)), 64'h0001);
        in_data = 16'h0002;
        #1;
        chk("s2_stall_ready", 64'(in_ready), 64'h0);
        step();
        chk("s2_ch1_held", 64'(dat(1)), 64'h0001);
        chk("s2_ch1_cnt1", 64'(cnt(1)), 64'h1);
        in_data = 16'hBEEF; in_sel = 2'd3;
        #1;
        chk("s3_ready_ch3", 64'(in_ready), 64'h1);
        step();
        chk("s3_out_valid", 64'(out_valid), 64'hA);
        chk("s3_ch3_data",  64'(dat(3)),    64'hBEEF);
        chk("s3_ch1_data",  64'(dat(1)),    64'h0001);
        in_data = 16'h0002; in_sel = 2'd1;
        #1;
        chk("s2_still_stall", 64'(in_ready), 64'h0);
        out_ready = 4'hF;
        #1;
        chk("s2_drain_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        chk("s2_out_valid", 64'(out_valid), 64'h2);
        chk("s2_ch1_data1", 64'(dat(1)),    64'h0002);
        chk("s2_ch1_cnt2",  64'(cnt(1)),    64'h2);
        step();
        chk("s2_drained", 64'(out_valid), 64'h0);

        // Scenario 4: streaming into ch0 at one beat per clock
        in_valid = 1'b1; in_sel = 2'd0;
        for (int k = 0; k < 8; k++) begin
            in_data = 16'h1000 + 16'(k);
            #1;
            chk("s4_ready", 64'(in_ready), 64'h1);
            step();
            chk("s4_valid", 64'(out_valid[0]), 64'h1);
            chk("s4_data",  64'(dat(0)),       64'h1000 + 64'(k));
        end
        in_valid = 1'b0;
        chk("s4_cnt0", 64'(cnt(0)), 64'h8);
        step();

        // Scenario 5: counter saturation, clear priority, reload
        in_valid = 1'b1; in_sel = 2'd3; in_data = 16'h3333;
        for (int k = 0; k < 300; k++) begin
            step();
        end
        chk("s5_sat", 64'(cnt(3)), 64'hFF);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("s5_clr_load",  64'(cnt(3)),     64'h0);
        chk("s5_clr_all",   64'(beat_cnt),   64'h0);
        chk("s5_load_kept", 64'(out_valid[3]), 64'h1);
        step();
        in_valid = 1'b0;
        chk("s5_reload", 64'(cnt(3)), 64'h1);
        step();

        // Scenario 6: asynchronous reset with ch0 and ch2 occupied
        out_ready = 4'h0;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 16'hAAAA;
        step();
        in_sel = 2'd2; in_data = 16'h5555;
        step();
        in_valid = 1'b0;
        chk("s6_pre_valid", 64'(out_valid), 64'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_valid", 64'(out_valid), 64'h0);
        chk("s6_async_cnt",   64'(beat_cnt),  64'h0);
        chk("s6_async_data",  out_data,       64'h0);
        #2;
        rst = 1'b0;
        out_ready = 4'hF;
        in_valid = 1'b1; in_data = 16'hA5A5; in_sel = 2'd2;
        step();
        in_valid = 1'b0;
        chk("s6_post_valid", 64'(out_valid), 64'h4);
        chk("s6_post_data",  64'(dat(2)),    64'hA5A5);
        chk("s6_post_cnt",   64'(cnt(2)),    64'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
